// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage registers of the CPU.
package pipe_pkg;

    // Occupancy of a skid stage: EMPTY (nothing held), ONE (main), TWO (main + skid).
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } state_t;

    // Payload widths of the inter-stage registers; callers pack/unpack the fields.
    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 128;
    localparam int EX_MEM_W = 112;
    localparam int MEM_WB_W = 80;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used by performance monitors.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Clear wins over increment; the count sticks at all-ones once reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic elastic pipeline-stage register with a 2-entry skid buffer, flush and
// a saturating stall counter.
//
// Handshake: a word moves across a port on every clock edge where valid and
// ready are both high; the sender holds valid and data stable until that edge,
// and ready never depends combinationally on the other side's valid/ready.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH        = 64,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0,
    parameter int               CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] stall_count,
    output state_t           o_dbg_state
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_main_vld;
    logic             w_skid_vld;
    logic             w_push;
    logic             w_pop;
    logic             w_stall;

    // The per-entry valid bits are implied by the occupancy state, so both
    // ready and valid come straight from registers.
    assign w_main_vld = (r_state != EMPTY);
    assign w_skid_vld = (r_state == TWO);
    assign in_ready   = ~w_skid_vld;
    assign out_valid  = w_main_vld;
    assign out_data   = r_main;
    assign o_dbg_state = r_state;

    assign w_push  = in_valid & in_ready;
    assign w_pop   = out_valid & out_ready;
    assign w_stall = out_valid & ~out_ready;

    // Next occupancy and payload; flush overrides any push or pop this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = EMPTY;
            w_main_nxt  = BUBBLE_VALUE;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = in_data;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        w_main_nxt = in_data;
                    end else if (w_push) begin
                        // Head is blocked: park the in-flight word behind it.
                        w_state_nxt = TWO;
                        w_skid_nxt  = in_data;
                    end else if (w_pop) begin
                        w_state_nxt = EMPTY;
                        w_main_nxt  = BUBBLE_VALUE;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the older skid word moves up.
                    if (w_pop) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                    w_main_nxt  = BUBBLE_VALUE;
                end
            endcase
        end
    end

    // State and payload registers; reset drops both entries immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
            r_main  <= BUBBLE_VALUE;
            r_skid  <= BUBBLE_VALUE;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (w_stall),
        .clr  (clr_stats),
        .count(stall_count)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage with a queue-based reference model.
module tb_pipe_skid_stage;
    import pipe_pkg::*;

    localparam int               W      = 16;
    localparam int               CW     = 16;
    localparam logic [W-1:0]     BUBBLE = 16'hB0B0;
    localparam int               CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          clr_stats = 1'b0;
    logic [CW-1:0] stall_count;
    state_t        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // Reference model: a FIFO of at most two words plus a stall tally.
    logic [W-1:0] mdl_q[$];
    int           mdl_stall = 0;

    // Words seen leaving the DUT and the cycle they left on.
    logic [W-1:0] pop_log[$];
    int           pop_cyc[$];

    pipe_skid_stage #(
        .WIDTH(W),
        .BUBBLE_VALUE(BUBBLE),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .clr_stats(clr_stats),
        .stall_count(stall_count),
        .o_dbg_state(dbg_state)
    );

    // Clock and cycle count.
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Model update from the rules: push when fewer than two held, pop when
    // something is held and downstream accepts; flush empties everything.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdl_q.delete();
            mdl_stall = 0;
        end else begin
            automatic bit push = in_valid && (mdl_q.size() < 2);
            automatic bit pop  = (mdl_q.size() > 0) && out_ready;
            if (clr_stats) mdl_stall = 0;
            else if ((mdl_q.size() > 0) && !out_ready && (mdl_stall < CMAX)) mdl_stall++;
            if (flush) begin
                mdl_q.delete();
            end else begin
                if (pop) void'(mdl_q.pop_front());
                if (push) mdl_q.push_back(in_data);
            end
        end
    end

    // Every-cycle compare against the model, plus the pop log.
    always @(negedge clk) begin
        if (!reset) begin
            automatic logic [W-1:0] e_data = (mdl_q.size() > 0) ? mdl_q[0] : BUBBLE;
            automatic state_t e_state = (mdl_q.size() == 0) ? EMPTY :
                                        (mdl_q.size() == 1) ? ONE : TWO;
            check("out_valid", 64'(out_valid), 64'(mdl_q.size() > 0));
            check("in_ready", 64'(in_ready), 64'(mdl_q.size() < 2));
            check("out_data", 64'(out_data), 64'(e_data));
            check("stall_count", 64'(stall_count), 64'(mdl_stall));
            check("state", 64'(dbg_state), 64'(e_state));
            if (out_valid && out_ready) begin
                pop_log.push_back(out_data);
                pop_cyc.push_back(cycle);
            end
        end
    end

    // Advance one edge; inputs change 2 time units after it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset block.
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'(out_data), 64'hB0B0);
        check("rst_stall", 64'(stall_count), 64'd0);
        tick();

        // Single word with out_ready high.
        out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h1111;
        tick();
        in_valid = 1'b0;
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_out_data", 64'(out_data), 64'h1111);
        check("t1_in_ready", 64'(in_ready), 64'd1);
        ticks(2);

        // Back-to-back stream 1..8.
        pop_log.delete(); pop_cyc.delete();
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = W'(i);
            tick();
        end
        in_valid = 1'b0;
        ticks(2);
        check("t2_pop_count", 64'(pop_log.size()), 64'd8);
        if (pop_log.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("t2_order", 64'(pop_log[i]), 64'(i + 1));
                if (i > 0) check("t2_no_bubble", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd1);
            end
        end

        // Fill to TWO under back-pressure, then drain.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h000A;
        tick();
        in_data = 16'h000B;
        tick();
        in_valid = 1'b0;
        check("t3_state_two", 64'(dbg_state), 64'(TWO));
        check("t3_in_ready_low", 64'(in_ready), 64'd0);
        check("t3_head", 64'(out_data), 64'h000A);
        check("t3_stall", 64'(stall_count), 64'd1);
        pop_log.delete(); pop_cyc.delete();
        out_ready = 1'b1;
        tick();
        check("t3_in_ready_back", 64'(in_ready), 64'd1);
        check("t3_next_head", 64'(out_data), 64'h000B);
        tick();
        check("t3_drained", 64'(out_valid), 64'd0);
        check("t3_pops", 64'(pop_log.size()), 64'd2);
        if (pop_log.size() == 2) begin
            check("t3_pop0", 64'(pop_log[0]), 64'h000A);
            check("t3_pop1", 64'(pop_log[1]), 64'h000B);
        end

        // Flush in TWO together with a push of 0xC.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0021;
        tick();
        in_data = 16'h0022;
        tick();
        pop_log.delete(); pop_cyc.delete();
        flush = 1'b1; in_valid = 1'b1; in_data = 16'h000C;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("t4_out_valid", 64'(out_valid), 64'd0);
        check("t4_out_data", 64'(out_data), 64'hB0B0);
        check("t4_in_ready", 64'(in_ready), 64'd1);
        check("t4_stall", 64'(stall_count), 64'd3);
        out_ready = 1'b1;
        ticks(3);
        check("t4_nothing_out", 64'(pop_log.size()), 64'd0);

        // Stall counter saturation and clear.
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("t5_cleared", 64'(stall_count), 64'd0);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h7777;
        tick();
        in_valid = 1'b0;
        ticks(70000);
        check("t5_saturated", 64'(stall_count), 64'hFFFF);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("t5_clr_wins", 64'(stall_count), 64'd0);
        out_ready = 1'b1;
        ticks(2);

        // Asynchronous reset while in ONE.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h5555;
        tick();
        in_valid = 1'b0;
        check("t6_pre_valid", 64'(out_valid), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("t6_async_valid", 64'(out_valid), 64'd0);
        check("t6_async_ready", 64'(in_ready), 64'd1);
        check("t6_async_data", 64'(out_data), 64'hB0B0);
        check("t6_async_stall", 64'(stall_count), 64'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
        tick();
        in_valid = 1'b0;
        check("t6_recover", 64'(out_data), 64'h1234);
        ticks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
